// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Gate-level half and full subtractor cells used by the serial datapath.

// Half subtractor: d = x - y (one bit), bout = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);

    logic xn_s;

    xor g_diff (d, x, y);
    not g_inv  (xn_s, x);
    and g_brw  (bout, xn_s, y);

endmodule : half_subtractor

// Full subtractor: two cascaded half subtractors, borrows merged by an OR.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1_s;
    logic b1_s;
    logic b2_s;

    half_subtractor u_hs0 (
        .x    (x),
        .y    (y),
        .d    (d1_s),
        .bout (b1_s)
    );

    half_subtractor u_hs1 (
        .x    (d1_s),
        .y    (bin),
        .d    (d),
        .bout (b2_s)
    );

    or g_bout (bout, b1_s, b2_s);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: latches a and b on start, processes one
// bit per clock LSB-first, then presents diff/borrow with a done pulse.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // One extra bit so the counter never wraps within an operation.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [WIDTH-1:0]   sr_r;
    logic [WIDTH-1:0]   sr_next_s;
    logic [WIDTH-1:0]   diff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               br_r;
    logic               borrow_r;
    logic               busy_r;
    logic               done_r;
    logic               d_s;
    logic               bout_s;
    logic               last_s;

    full_subtractor u_fs (
        .x    (sa_r[0]),
        .y    (sb_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_s    = (cnt_r == LAST_CNT);
    assign sr_next_s = {d_s, sr_r[WIDTH-1:1]};

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand/result shift registers, bit counter and running borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            sr_r  <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            br_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r  <= a;
                        sb_r  <= b;
                        cnt_r <= {CNT_W{1'b0}};
                        br_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    sr_r  <= sr_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    br_r  <= bout_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: updated only on the final bit-step, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            diff_r   <= sr_next_s;
            borrow_r <= bout_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, start3;
    logic [7:0] a8, b8;
    logic [2:0] a3, b3;
    logic       busy8, done8, borrow8;
    logic       busy3, done3, borrow3;
    logic [7:0] diff8;
    logic [2:0] diff3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t tbl [6];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .start  (start3),
        .a      (a3),
        .b      (b3),
        .busy   (busy3),
        .done   (done3),
        .diff   (diff3),
        .borrow (borrow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global cycle counter for done-to-done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally pulses start with other operands at RUN cycle inj.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input int inj, input string tag);
        int k;
        int bc;
        int dc;
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        k = 0;
        bc = 0;
        while (!done8 && k < 40) begin
            if (busy8) bc++;
            if (k == inj) begin
                start8 = 1'b1;
                a8 = ~av;
                b8 = av;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start8 = 1'b0;
        if (busy8) bc++;
        chk({tag, "_latency"}, 32'(k), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd9);
        chk({tag, "_diff"}, 32'(diff8), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow8), 32'(eb));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy8), 32'd0);
        dc = 0;
        for (int j = 0; j < 12; j++) begin
            if (done8) dc++;
            @(negedge clk);
        end
        chk({tag, "_extra_done"}, 32'(dc), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff8), 32'(ed));
        chk({tag, "_borrow_hold"}, 32'(borrow8), 32'(eb));
    endtask

    // Back-to-back random operations with start held high, checked against plain arithmetic.
    task automatic stream(input int w, input int n);
        int          k;
        int          last_cyc;
        int unsigned ra;
        int unsigned rb;
        int unsigned mask;
        logic        dn;
        logic [31:0] ad;
        logic        ab;
        mask = (32'd1 << w) - 32'd1;
        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            ra = $urandom_range(0, mask);
            rb = $urandom_range(0, mask);
            if (w == 8) begin
                a8 = 8'(ra);
                b8 = 8'(rb);
                start8 = 1'b1;
            end else begin
                a3 = 3'(ra);
                b3 = 3'(rb);
                start3 = 1'b1;
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
                dn = (w == 8) ? done8 : done3;
            end while (!dn && k < 50);
            ad = (w == 8) ? 32'(diff8) : 32'(diff3);
            ab = (w == 8) ? borrow8 : borrow3;
            chk("stream_done_seen", 32'(dn), 32'd1);
            chk("stream_diff", ad, (ra - rb) & mask);
            chk("stream_borrow", 32'(ab), 32'(ra < rb));
            if (i > 0) chk("stream_spacing", 32'(cyc - last_cyc), 32'(w + 2));
            last_cyc = cyc;
        end
        start8 = 1'b0;
        start3 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int dc;
        tbl[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
        tbl[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
        tbl[2] = '{8'd200, 8'd200, 8'd0,   1'b0};
        tbl[3] = '{8'd0,   8'd255, 8'd1,   1'b1};
        tbl[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
        tbl[5] = '{8'd1,   8'd2,   8'd255, 1'b1};

        rst = 1'b1;
        start8 = 1'b0;
        start3 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        a3 = 3'd0;
        b3 = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_borrow", 32'(borrow8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].ed, tbl[i].eb, -1, $sformatf("vec%0d", i));
        end

        // Start pulsed mid-RUN with different operands must be ignored.
        op8(8'd77, 8'd12, 8'd65, 1'b0, 3, "midrun");

        // Reset in the fourth RUN cycle aborts the operation with no done pulse.
        start8 = 1'b1;
        a8 = 8'd10;
        b8 = 8'd20;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_borrow", 32'(borrow8), 32'd0);
        dc = 0;
        for (int j = 0; j < 15; j++) begin
            if (done8) dc++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dc), 32'd0);
        op8(8'd100, 8'd37, 8'd63, 1'b0, -1, "after_abort");

        stream(8, 1000);
        stream(3, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_subtractor
